module_ejecutor_alu: RTL and testbench

MODULE_EJECUTOR_ALU -- requirements
Module: module_ejecutor_alu

---
 rtl/module_ejecutor_alu.sv | 126 ++++++++++++
 tb/tb_module_ejecutor_alu.sv | 151 +++++++++++++++
 2 files changed

// File: rtl/module_ejecutor_alu.sv
// module_ejecutor_alu: four-state ALU instruction executor driving an external register file
// Ports:
//   clk, rst                   clock and synchronous active-high reset
//   instr_valid / instr_ready  instruction handshake (accepted only in IDLE)
//   op, addr_a, addr_b, addr_d operation select, source A/B and destination indices
//   addr_rs1, addr_rs2         register-file read addresses (latched addr_a / addr_b)
//   rs1, rs2                   combinational read data from the register file
//   addr_rd, we, data_out      register-file write port, active in WRITE
//   done                       one-cycle completion pulse in WRITE
//   flag_zero, flag_carry      status of the last executed instruction
// Optional feature: define EJECUTOR_SAT_EN to saturate ADD/SUB results.
module module_ejecutor_alu #(
    parameter int N = 32,
    parameter int W = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 instr_valid,
    output logic                 instr_ready,
    input  logic [2:0]           op,
    input  logic [$clog2(N)-1:0] addr_a,
    input  logic [$clog2(N)-1:0] addr_b,
    input  logic [$clog2(N)-1:0] addr_d,
    output logic [$clog2(N)-1:0] addr_rs1,
    output logic [$clog2(N)-1:0] addr_rs2,
    input  logic [W-1:0]         rs1,
    input  logic [W-1:0]         rs2,
    output logic [$clog2(N)-1:0] addr_rd,
    output logic                 we,
    output logic [W-1:0]         data_out,
    output logic                 done,
    output logic                 flag_zero,
    output logic                 flag_carry
);
    localparam int AW = $clog2(N);
    typedef enum logic [1:0] {IDLE, READ, EXEC, WRITE} state_t;
    state_t state, state_nx;
    logic [2:0]    op_q;
    logic [AW-1:0] a_q, b_q, d_q;
    logic [W-1:0]  opa, opb, result, res_nx;
    logic          carry_nx;
    logic [W:0]    sum, diff;
    logic [31:0]   sh;
    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nx;
    end
    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    state_nx = instr_valid ? READ : IDLE;
            READ:    state_nx = EXEC;
            EXEC:    state_nx = WRITE;
            default: state_nx = IDLE;
        endcase
    end
    // Borrow of the subtraction appears as bit W of the widened difference.
    always_comb begin
        sum      = {1'b0, opa} + {1'b0, opb};
        diff     = {1'b0, opa} - {1'b0, opb};
        sh       = 32'(opb) % W;
        res_nx   = opa;
        carry_nx = 1'b0;
        case (op_q)
            3'b000: begin
`ifdef EJECUTOR_SAT_EN
                res_nx = sum[W] ? '1 : sum[W-1:0];
`else
                res_nx = sum[W-1:0];
`endif
                carry_nx = sum[W];
            end
            3'b001: begin
`ifdef EJECUTOR_SAT_EN
                res_nx = diff[W] ? '0 : diff[W-1:0];
`else
                res_nx = diff[W-1:0];
`endif
                carry_nx = diff[W];
            end
            3'b010:  res_nx = opa & opb;
            3'b011:  res_nx = opa | opb;
            3'b100:  res_nx = opa ^ opb;
            3'b101:  res_nx = opa << sh;
            3'b110:  res_nx = opa >> sh;
            default: res_nx = opa;
        endcase
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            op_q       <= '0;
            a_q        <= '0;
            b_q        <= '0;
            d_q        <= '0;
            opa        <= '0;
            opb        <= '0;
            result     <= '0;
            flag_zero  <= 1'b0;
            flag_carry <= 1'b0;
        end else begin
            if (state == IDLE && instr_valid) begin
                op_q <= op;
                a_q  <= addr_a;
                b_q  <= addr_b;
                d_q  <= addr_d;
            end
            if (state == READ) begin
                opa <= rs1;
                opb <= rs2;
            end
            if (state == EXEC) begin
                result     <= res_nx;
                flag_zero  <= (res_nx == '0);
                flag_carry <= carry_nx;
            end
        end
    end
    // Outputs are gated by rst so they read zero during reset regardless of state.
    assign instr_ready = (state == IDLE) && !rst;
    assign addr_rs1    = rst ? '0 : a_q;
    assign addr_rs2    = rst ? '0 : b_q;
    assign addr_rd     = rst ? '0 : d_q;
    assign data_out    = rst ? '0 : result;
    assign done        = (state == WRITE) && !rst;
    assign we          = done && (d_q != '0);
endmodule

// File: tb/tb_module_ejecutor_alu.sv
// tb_module_ejecutor_alu: directed self-checking bench for module_ejecutor_alu with a register-file model
module tb_module_ejecutor_alu;
    logic       clk = 1'b0;
    logic       rst;
    logic       instr_valid, instr_ready;
    logic [2:0] op;
    logic [4:0] addr_a, addr_b, addr_d, addr_rs1, addr_rs2, addr_rd;
    logic [3:0] rs1, rs2, data_out;
    logic       we, done, flag_zero, flag_carry;
    logic [3:0] rf [32];
    int n_checks = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    module_ejecutor_alu dut (
        .clk(clk), .rst(rst), .instr_valid(instr_valid), .instr_ready(instr_ready),
        .op(op), .addr_a(addr_a), .addr_b(addr_b), .addr_d(addr_d),
        .addr_rs1(addr_rs1), .addr_rs2(addr_rs2), .rs1(rs1), .rs2(rs2),
        .addr_rd(addr_rd), .we(we), .data_out(data_out), .done(done),
        .flag_zero(flag_zero), .flag_carry(flag_carry)
    );

    assign rs1 = rf[addr_rs1];
    assign rs2 = rf[addr_rs2];
    always @(posedge clk) if (we) rf[addr_rd] <= data_out;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, act, exp);
        end
    endtask

    // Offers one instruction in IDLE, scrambles inputs after accept, returns in the WRITE cycle.
    task automatic issue(input logic [2:0] o, input logic [4:0] a, input logic [4:0] b, input logic [4:0] d);
        @(negedge clk);
        check("ready_idle", instr_ready, 1);
        instr_valid = 1'b1; op = o; addr_a = a; addr_b = b; addr_d = d;
        @(posedge clk);
        #1 instr_valid = 1'b0; op = 3'b111; addr_a = 5'd0; addr_b = 5'd0; addr_d = 5'd31;
        @(negedge clk);
        check("read_no_done", done, 0);
        check("read_no_ready", instr_ready, 0);
        @(negedge clk);
        check("exec_no_we", we, 0);
        @(negedge clk);
    endtask

    task automatic exec_chk(input string tag, input logic [2:0] o, input logic [4:0] a, input logic [4:0] b,
                            input logic [4:0] d, input logic [3:0] exp_d, input logic exp_z, input logic exp_c);
        issue(o, a, b, d);
        check({tag, "_done"}, done, 1);
        check({tag, "_we"}, we, d != 0);
        check({tag, "_addr_rd"}, addr_rd, d);
        check({tag, "_data"}, data_out, exp_d);
        check({tag, "_zero"}, flag_zero, exp_z);
        check({tag, "_carry"}, flag_carry, exp_c);
    endtask

    initial begin
        int dn, wn, acc, last_acc, gap_ok;
        logic sat;
`ifdef EJECUTOR_SAT_EN
        sat = 1'b1;
`else
        sat = 1'b0;
`endif
        foreach (rf[i]) rf[i] = 4'd0;
        rf[1] = 4'd9; rf[2] = 4'd8; rf[5] = 4'd7; rf[6] = 4'd5; rf[7] = 4'd3;
        rst = 1'b1; instr_valid = 1'b1; op = 3'b000; addr_a = 5'd1; addr_b = 5'd2; addr_d = 5'd3;
        repeat (2) @(negedge clk);
        check("rst_ready", instr_ready, 0);
        check("rst_we", we, 0);
        check("rst_done", done, 0);
        check("rst_data", data_out, 0);
        check("rst_rs1", addr_rs1, 0);
        check("rst_rs2", addr_rs2, 0);
        check("rst_rd", addr_rd, 0);
        check("rst_flags", {flag_zero, flag_carry}, 0);
        instr_valid = 1'b0;
        @(posedge clk);
        #1 rst = 1'b0;

        exec_chk("add", 3'b000, 1, 2, 3, sat ? 4'd15 : 4'd1, 0, 1);
        exec_chk("sub", 3'b001, 2, 1, 4, sat ? 4'd0 : 4'd15, sat, 1);
        exec_chk("xor", 3'b100, 1, 1, 5, 0, 1, 0);
        exec_chk("r5_read", 3'b111, 5, 0, 9, 0, 1, 0);
        exec_chk("and", 3'b010, 1, 2, 10, 8, 0, 0);
        exec_chk("or", 3'b011, 1, 2, 11, 9, 0, 0);
        exec_chk("sll", 3'b101, 1, 6, 12, 2, 0, 0);
        exec_chk("srl", 3'b110, 1, 6, 13, 4, 0, 0);
        exec_chk("sub_nb", 3'b001, 1, 2, 14, 1, 0, 0);
        exec_chk("add_self", 3'b000, 7, 7, 7, 6, 0, 0);
        exec_chk("r7_read", 3'b111, 7, 0, 15, 6, 0, 0);
        exec_chk("add_r0", 3'b000, 1, 2, 0, sat ? 4'd15 : 4'd1, 0, 1);
        exec_chk("add_ovf", 3'b000, 1, 1, 16, sat ? 4'd15 : 4'd2, 0, 1);
        @(negedge clk);
        check("r0_unwritten", rf[0], 0);
        check("r3_written", rf[3], sat ? 4'd15 : 4'd1);

        // Abort while in EXEC.
        check("abort_ready", instr_ready, 1);
        instr_valid = 1'b1; op = 3'b000; addr_a = 5'd2; addr_b = 5'd2; addr_d = 5'd17;
        @(posedge clk);
        #1 instr_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        #1;
        check("abort_rst_ready", instr_ready, 0);
        check("abort_rst_we", we, 0);
        check("abort_rst_rd", addr_rd, 0);
        check("abort_rst_rs1", addr_rs1, 0);
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("abort_ready_after", instr_ready, 1);
        check("abort_flags", {flag_zero, flag_carry}, 0);
        dn = 0; wn = 0;
        repeat (6) begin
            dn += int'(done); wn += int'(we);
            @(negedge clk);
        end
        check("abort_done_cnt", dn, 0);
        check("abort_we_cnt", wn, 0);
        check("abort_r17", rf[17], 0);

        // Valid held high for 12 cycles.
        instr_valid = 1'b1; op = 3'b000; addr_a = 5'd1; addr_b = 5'd2; addr_d = 5'd18;
        dn = 0; acc = 0; last_acc = -4; gap_ok = 1;
        for (int i = 0; i < 12; i++) begin
            if (instr_ready && instr_valid) begin
                if (i - last_acc != 4) gap_ok = 0;
                last_acc = i;
                acc++;
            end
            dn += int'(done);
            @(negedge clk);
        end
        instr_valid = 1'b0;
        check("held_accepts", acc, 3);
        check("held_spacing", gap_ok, 1);
        check("held_done", dn, 3);
        check("held_idle", instr_ready, 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
